// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity receive/transmit path.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } pfc_state_t;

  localparam bit PARITY_EVEN    = 1'b0;
  localparam bit PARITY_ODD_SEL = 1'b1;

endpackage

// File: rtl/parity_acc.sv
// 1-bit XOR accumulator; clr has priority over en. Shared by RX and TX sides.
module parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic acc
);

  // Running XOR of every bit presented while en is high since the last clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= 1'b0;
    end else if (clr) begin
      acc <= 1'b0;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/parity_frame_checker.sv
// Serial frame receiver: start, DATA_W data bits LSB-first, parity, stop.
// Reports each completed frame with a one-cycle valid plus parity/framing flags.
// Optional feature: define PARITY_FRAME_ERRCNT_EN to add a saturating 8-bit
// errored-frame counter on output err_cnt.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W     = 3,
  parameter bit          PARITY_ODD = PARITY_EVEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
`ifdef PARITY_FRAME_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  pfc_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shift;
  logic              acc;
  logic              acc_clr_c;
  logic              acc_en_c;

  // Accumulator is cleared on the start bit and folds in data and parity bits.
  assign acc_clr_c = bit_en && (state == IDLE) && !rx_in;
  assign acc_en_c  = bit_en && ((state == DATA) || (state == PAR));

  parity_acc u_acc (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr_c),
    .en  (acc_en_c),
    .din (rx_in),
    .acc (acc)
  );

  // Frame FSM with registered result outputs; bit_en=0 freezes everything but the pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shift      <= '0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (bit_en) begin
        case (state)
          IDLE: begin
            if (!rx_in) begin
              state <= DATA;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          DATA: begin
            for (int i = 0; i < int'(DATA_W); i++) begin
              if (cnt == CNT_W'(i)) shift[i] <= rx_in;
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) state <= PAR;
          end
          PAR: begin
            state <= STOP;
          end
          STOP: begin
            state      <= IDLE;
            data_out   <= shift;
            parity_err <= (acc != PARITY_ODD);
            frame_err  <= !rx_in;
            valid      <= 1'b1;
            busy       <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PARITY_FRAME_ERRCNT_EN
  // Saturating count of reported frames carrying any error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (valid && (parity_err || frame_err) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: fixed vectors, hand corner sequences and
// random frames checked against a frame-level reference model.
module tb_parity_frame_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       bit_en;
  logic [2:0] data_out, data_o;
  logic       valid, parity_err, frame_err, busy;
  logic       valid_o, perr_o, ferr_o, busy_o;
`ifdef PARITY_FRAME_ERRCNT_EN
  logic [7:0] err_cnt, err_cnt_o;
`endif

  always #5 clk = ~clk;

  parity_frame_checker #(.DATA_W(3), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .bit_en(bit_en),
    .data_out(data_out), .valid(valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
`ifdef PARITY_FRAME_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  parity_frame_checker #(.DATA_W(3), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .rx_in(rx_in), .bit_en(bit_en),
    .data_out(data_o), .valid(valid_o), .parity_err(perr_o),
    .frame_err(ferr_o), .busy(busy_o)
`ifdef PARITY_FRAME_ERRCNT_EN
    , .err_cnt(err_cnt_o)
`endif
  );

  typedef struct {
    logic [2:0] d;
    logic       pe;
    logic       pe_o;
    logic       fe;
  } exp_t;

  typedef struct {
    logic [2:0] data;
    logic       p;
    logic       stop;
    logic [2:0] e_data;
    logic       e_perr;
    logic       e_perr_odd;
    logic       e_ferr;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_push = 0;
  int   n_valid = 0;
  int   n_err_frames = 0;
  exp_t q[$];
  logic prev_valid = 1'b0;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: even parity error when the total count of ones is odd, odd parity the reverse.
  function automatic exp_t model(logic [2:0] d, logic p, logic s);
    exp_t e;
    int   ones;
    ones   = $countones(d) + int'(p);
    e.d    = d;
    e.pe   = (ones % 2) != 0;
    e.pe_o = (ones % 2) != 1;
    e.fe   = !s;
    return e;
  endfunction

  task automatic drive(input logic en, input logic b);
    @(negedge clk);
    bit_en = en;
    rx_in  = b;
  endtask

  // Sends one frame; 'gap' idle cycles with bit_en=0 and random rx_in precede each sample.
  task automatic send_frame(input logic [2:0] d, input logic p, input logic s, input int gap);
    logic [5:0] bits;
    exp_t       e;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < 6; i++) begin
      repeat (gap) drive(1'b0, 1'($urandom_range(0, 1)));
      if (i == 5) begin
        e = model(d, p, s);
        q.push_back(e);
        n_push++;
        if (e.pe || e.fe) n_err_frames++;
      end
      drive(1'b1, bits[i]);
    end
  endtask

  // Scoreboard: every valid must match the oldest expected frame, on both instances.
  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      n_valid++;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got valid=1 expected no frame pending (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        check("sb_data", int'(data_out), int'(e.d));
        check("sb_parity_err", int'(parity_err), int'(e.pe));
        check("sb_frame_err", int'(frame_err), int'(e.fe));
        check("sb_odd_data", int'(data_o), int'(e.d));
        check("sb_odd_parity_err", int'(perr_o), int'(e.pe_o));
        check("sb_odd_frame_err", int'(ferr_o), int'(e.fe));
        check("sb_busy_low_with_valid", int'(busy), 0);
      end
      check("sb_valid_single_cycle", int'(prev_valid), 0);
    end
    check("sb_odd_valid_agrees", int'(valid_o), int'(valid));
    prev_valid = valid;
  end

  vec_t vecs[5];

  initial begin
    vecs[0] = '{3'b101, 1'b0, 1'b1, 3'b101, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{3'b101, 1'b1, 1'b1, 3'b101, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{3'b011, 1'b0, 1'b0, 3'b011, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{3'b110, 1'b1, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{3'b111, 1'b1, 1'b0, 3'b111, 1'b0, 1'b1, 1'b1};

    rst    = 1'b1;
    bit_en = 1'b0;
    rx_in  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_out", int'(data_out), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_parity_err", int'(parity_err), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // Idle-high samples must not start a frame.
    repeat (4) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    check("idle_busy", int'(busy), 0);

    // Table: back-to-back-free frames with results checked in the cycle after the stop sample.
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].data, vecs[v].p, vecs[v].stop, 0);
      drive(1'b0, 1'b1);
      check("tbl_valid", int'(valid), 1);
      check("tbl_data_out", int'(data_out), int'(vecs[v].e_data));
      check("tbl_parity_err", int'(parity_err), int'(vecs[v].e_perr));
      check("tbl_frame_err", int'(frame_err), int'(vecs[v].e_ferr));
      check("tbl_odd_parity_err", int'(perr_o), int'(vecs[v].e_perr_odd));
      drive(1'b0, 1'b1);
      check("tbl_valid_cleared", int'(valid), 0);
      check("tbl_data_held", int'(data_out), int'(vecs[v].e_data));
    end

    // busy rises the cycle after the start sample.
    drive(1'b1, 1'b0);
    check("busy_before_start_edge", int'(busy), 0);
    drive(1'b0, 1'b0);
    check("busy_after_start", int'(busy), 1);
    begin
      exp_t e;
      logic [4:0] rest;
      rest = {1'b1, 1'b0, 3'b010};
      for (int i = 0; i < 5; i++) begin
        if (i == 4) begin
          e = model(3'b010, 1'b0, 1'b1);
          q.push_back(e);
          n_push++;
          if (e.pe || e.fe) n_err_frames++;
        end
        drive(1'b1, rest[i]);
      end
    end
    drive(1'b0, 1'b1);
    check("busy_falls_with_valid", int'(busy), 0);
    check("busy_seq_valid", int'(valid), 1);

    // Sparse strobe: sample every 4th cycle, line toggling in between.
    send_frame(3'b110, 1'b0, 1'b1, 3);
    drive(1'b0, 1'b0);
    check("sparse_valid", int'(valid), 1);
    check("sparse_data_out", int'(data_out), 6);
    check("sparse_parity_err", int'(parity_err), 0);
    check("sparse_frame_err", int'(frame_err), 0);
    repeat (3) drive(1'b0, 1'($urandom_range(0, 1)));

    // Reset after two data bits discards the partial frame.
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    @(negedge clk);
    rst    = 1'b1;
    bit_en = 1'b1;
    rx_in  = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
    bit_en = 1'b0;
    rx_in  = 1'b1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(valid), 0);
    send_frame(3'b001, 1'b1, 1'b1, 0);
    drive(1'b0, 1'b1);
    check("postrst_valid", int'(valid), 1);
    check("postrst_data_out", int'(data_out), 1);
    check("postrst_parity_err", int'(parity_err), 0);
    check("postrst_frame_err", int'(frame_err), 0);

    // Random frames, including back-to-back, sparse strobes and idle samples.
    for (int f = 0; f < 60; f++) begin
      int gap;
      int idle;
      gap  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      send_frame(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), gap);
      idle = int'($urandom_range(0, 2));
      for (int k = 0; k < idle; k++) begin
        if ($urandom_range(0, 1) == 0) drive(1'b1, 1'b1);
        else drive(1'b0, 1'($urandom_range(0, 1)));
      end
    end

`ifdef PARITY_FRAME_ERRCNT_EN
    for (int f = 0; f < 260; f++) send_frame(3'b101, 1'b1, 1'b1, 0);
    repeat (4) drive(1'b0, 1'b1);
    check("errcnt_saturated", int'(err_cnt),
          (n_err_frames > 255) ? 255 : n_err_frames);
    repeat (10) drive(1'b0, 1'b1);
    check("errcnt_held", int'(err_cnt), 255);
`endif

    repeat (4) drive(1'b0, 1'b1);
    check("all_frames_reported", n_valid, n_push);
    check("scoreboard_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
